// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Bridges a single outstanding CPU load/store request onto a simple
//   word-addressed memory port. One request at a time: IDLE accepts,
//   ACCESS drives the memory port for ACCESS_CYCLES cycles, RESP holds the
//   response until the CPU takes it.
//
//   Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
//   accesses (respond with resp_error=1, no memory access). Without it,
//   misaligned accesses go to memory with the out-of-word lanes dropped and
//   resp_error is constant 0.
//
// Parameters
//   ACCESS_CYCLES    cycles mem_valid is held per access (1..15)
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   req_valid/ready  CPU request handshake (ready only in IDLE)
//   req_write        1 = store, 0 = load
//   req_addr         byte address
//   req_wdata        store data, right-aligned
//   req_size         0 byte, 1 half, 2/3 word
//   req_unsigned     load zero-extends when 1, sign-extends when 0
//   resp_valid/ready response handshake
//   resp_rdata       extended load data (0 for stores)
//   resp_error       misaligned-access trap
//   mem_valid        memory access active (ACCESS state only)
//   mem_write_enable one-cycle write strobe in the last ACCESS cycle of a store
//   mem_write_addr   word-aligned write address
//   mem_write_data   store data shifted into its byte lanes
//   mem_write_mask   byte-lane enables
//   mem_read_addr    word-aligned read address
//   mem_read_data    combinational read data from memory
module lsu_mem_master #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_valid,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data
);

    // Down-counter start value: the final ACCESS cycle is the one with cnt==0.
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    // Captured request fields still needed after acceptance.
    logic       write_q;
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       uns_q;

    // Byte-lane enables; lanes shifted past bit 3 fall off the 4-bit result.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Align the addressed lane down to bit 0, then size-mask and extend.
    function automatic logic [31:0] extend_load(input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        sh = data >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            2'd0:    r = uns ? {24'd0, sh[7:0]}  : 32'(b);
            2'd1:    r = uns ? {16'd0, sh[15:0]} : 32'(h);
            default: r = sh;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = off[0];
            default: m = (off != 2'd0);
        endcase
        return m;
    endfunction
`else
    assign resp_error = 1'b0;
`endif

    // Request capture: pure data, only consulted after acceptance, so no reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && req_valid) begin
            write_q <= req_write;
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
        end
    end

    // Control FSM with registered outputs. Async reset clears every output
    // at once, which also kills any pending write strobe mid-access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_error       <= 1'b0;
`endif
            mem_valid        <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_write_addr   <= 32'd0;
            mem_write_data   <= 32'd0;
            mem_write_mask   <= 4'd0;
            mem_read_addr    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
`else
                        begin
`endif
                            state            <= ACCESS;
                            cnt              <= CNT_INIT;
                            mem_valid        <= 1'b1;
                            // Single-cycle access: the first ACCESS cycle is also the last.
                            mem_write_enable <= req_write && (CNT_INIT == 4'd0);
                            mem_read_addr    <= {req_addr[31:2], 2'b00};
                            mem_write_addr   <= req_write ? {req_addr[31:2], 2'b00} : 32'd0;
                            mem_write_data   <= req_write ? (req_wdata << {req_addr[1:0], 3'b000}) : 32'd0;
                            mem_write_mask   <= req_write ? lane_mask(req_size, req_addr[1:0]) : 4'd0;
                        end
                    end
                end

                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state            <= RESP;
                        resp_valid       <= 1'b1;
                        resp_rdata       <= write_q ? 32'd0
                                                    : extend_load(mem_read_data, off_q, size_q, uns_q);
                        mem_valid        <= 1'b0;
                        mem_write_enable <= 1'b0;
                        mem_write_addr   <= 32'd0;
                        mem_write_data   <= 32'd0;
                        mem_write_mask   <= 4'd0;
                        mem_read_addr    <= 32'd0;
                    end else begin
                        cnt              <= cnt - 4'd1;
                        // Strobe lands on the cycle where cnt will read 0.
                        mem_write_enable <= write_q && (cnt == 4'd1);
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                        resp_error <= 1'b0;
`endif
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_a, rst_b;
    logic        req_valid, req_write, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata, mem_read_data;
    logic [1:0]  req_size;

    logic        a_req_ready, a_resp_valid, a_resp_error, a_mem_valid, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_waddr, a_mem_wdata, a_mem_raddr;
    logic [3:0]  a_mem_wmask;
    logic        b_req_ready, b_resp_valid, b_resp_error, b_mem_valid, b_mem_we;
    logic [31:0] b_resp_rdata, b_mem_waddr, b_mem_wdata, b_mem_raddr;
    logic [3:0]  b_mem_wmask;

    int checks = 0;
    int errors = 0;

    // Instance A: single-cycle access. Instance B: three-cycle access.
    // They share request inputs; the one not under test is held in reset.
    lsu_mem_master #(.ACCESS_CYCLES(1)) u_a (
        .clock(clk), .reset(rst_a),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_error), .mem_valid(a_mem_valid),
        .mem_write_enable(a_mem_we), .mem_write_addr(a_mem_waddr),
        .mem_write_data(a_mem_wdata), .mem_write_mask(a_mem_wmask),
        .mem_read_addr(a_mem_raddr), .mem_read_data(mem_read_data)
    );

    lsu_mem_master #(.ACCESS_CYCLES(3)) u_b (
        .clock(clk), .reset(rst_b),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error), .mem_valid(b_mem_valid),
        .mem_write_enable(b_mem_we), .mem_write_addr(b_mem_waddr),
        .mem_write_data(b_mem_wdata), .mem_write_mask(b_mem_wmask),
        .mem_read_addr(b_mem_raddr), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [1:0] sz, input logic uns);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'd0;
        resp_ready = 1'b1; mem_read_data = 32'd0;
        tick(); tick();

        // Reset values
        chk1 ("rst_req_ready",  a_req_ready,  1'b1);
        chk1 ("rst_resp_valid", a_resp_valid, 1'b0);
        chk1 ("rst_mem_valid",  a_mem_valid,  1'b0);
        chk1 ("rst_mem_we",     a_mem_we,     1'b0);
        chk32("rst_resp_rdata", a_resp_rdata, 32'h0);
        chk4 ("rst_mem_wmask",  a_mem_wmask,  4'h0);

        rst_a = 1'b1;
        tick();

        // Word store, single-cycle access
        drive_req(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0);
        tick();
        req_valid = 1'b0;
        chk1 ("st_w_req_ready", a_req_ready, 1'b0);
        chk1 ("st_w_mem_valid", a_mem_valid, 1'b1);
        chk1 ("st_w_we",        a_mem_we,    1'b1);
        chk4 ("st_w_mask",      a_mem_wmask, 4'b1111);
        chk32("st_w_waddr",     a_mem_waddr, 32'h8000_0004);
        chk32("st_w_wdata",     a_mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk1 ("st_w_we_off",    a_mem_we,     1'b0);
        chk1 ("st_w_mv_off",    a_mem_valid,  1'b0);
        chk1 ("st_w_resp",      a_resp_valid, 1'b1);
        chk32("st_w_rdata",     a_resp_rdata, 32'h0);
        chk1 ("st_w_err",       a_resp_error, 1'b0);
        tick();
        chk1 ("st_w_idle",      a_req_ready,  1'b1);
        chk1 ("st_w_resp_off",  a_resp_valid, 1'b0);

        // Signed byte load from lane 3, two-cycle latency
        mem_read_data = 32'h8012_3456;
        drive_req(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0);
        tick();
        req_valid = 1'b0;
        chk1 ("ld_b_mv",     a_mem_valid,  1'b1);
        chk1 ("ld_b_we",     a_mem_we,     1'b0);
        chk32("ld_b_raddr",  a_mem_raddr,  32'h8000_0000);
        chk1 ("ld_b_lat1",   a_resp_valid, 1'b0);
        tick();
        chk1 ("ld_b_lat2",   a_resp_valid, 1'b1);
        chk32("ld_b_rdata",  a_resp_rdata, 32'hFFFF_FF80);
        tick();

        // Unsigned byte load, same word
        drive_req(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        chk1 ("ld_bu_resp",  a_resp_valid, 1'b1);
        chk32("ld_bu_rdata", a_resp_rdata, 32'h0000_0080);
        tick();

        // Signed half load from upper half
        mem_read_data = 32'h8001_7FFF;
        drive_req(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        chk32("ld_h_rdata",  a_resp_rdata, 32'hFFFF_8001);
        tick();

        // Half store into upper lanes
        drive_req(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0);
        tick();
        req_valid = 1'b0;
        chk4 ("st_h_mask",   a_mem_wmask, 4'b1100);
        chk32("st_h_wdata",  a_mem_wdata, 32'h1234_0000);
        chk32("st_h_waddr",  a_mem_waddr, 32'h8000_0000);
        chk1 ("st_h_we",     a_mem_we,    1'b1);
        tick(); tick();

        // Byte store into lane 1
        drive_req(1'b1, 32'h8000_0011, 32'h0000_00AB, 2'd0, 1'b0);
        tick();
        req_valid = 1'b0;
        chk4 ("st_b_mask",   a_mem_wmask, 4'b0010);
        chk32("st_b_wdata",  a_mem_wdata, 32'h0000_AB00);
        chk32("st_b_waddr",  a_mem_waddr, 32'h8000_0010);
        tick(); tick();

        // Misaligned word load
        mem_read_data = 32'hA1B2_C3D4;
        drive_req(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
        tick();
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        chk1 ("mis_mv",      a_mem_valid,  1'b0);
        chk1 ("mis_resp",    a_resp_valid, 1'b1);
        chk1 ("mis_err",     a_resp_error, 1'b1);
        chk32("mis_rdata",   a_resp_rdata, 32'h0);
        tick();
`else
        chk1 ("mis_mv",      a_mem_valid,  1'b1);
        chk32("mis_raddr",   a_mem_raddr,  32'h8000_0000);
        tick();
        chk1 ("mis_mv_off",  a_mem_valid,  1'b0);
        chk1 ("mis_resp",    a_resp_valid, 1'b1);
        chk1 ("mis_err",     a_resp_error, 1'b0);
        chk32("mis_rdata",   a_resp_rdata, 32'h00A1_B2C3);
        tick();
`endif
        chk1 ("mis_idle",    a_req_ready,  1'b1);

        // Switch to the three-cycle instance
        rst_a = 1'b0;
        rst_b = 1'b1;
        resp_ready = 1'b0;
        tick();
        chk1 ("b_idle",      b_req_ready,  1'b1);

        // Three-cycle store with a stalled response; req_valid stays high
        // with a different address to show it is ignored mid-transaction.
        drive_req(1'b1, 32'h0000_0010, 32'h55AA_55AA, 2'd2, 1'b0);
        tick();
        req_addr = 32'h0000_0020;
        chk1 ("b3_c1_mv",    b_mem_valid, 1'b1);
        chk1 ("b3_c1_we",    b_mem_we,    1'b0);
        tick();
        chk1 ("b3_c2_mv",    b_mem_valid, 1'b1);
        chk1 ("b3_c2_we",    b_mem_we,    1'b0);
        chk32("b3_c2_waddr", b_mem_waddr, 32'h0000_0010);
        req_valid = 1'b0;
        tick();
        chk1 ("b3_c3_mv",    b_mem_valid, 1'b1);
        chk1 ("b3_c3_we",    b_mem_we,    1'b1);
        chk32("b3_c3_wdata", b_mem_wdata, 32'h55AA_55AA);
        tick();
        chk1 ("b3_mv_off",   b_mem_valid, 1'b0);
        chk1 ("b3_we_off",   b_mem_we,    1'b0);
        for (int i = 0; i < 5; i++) begin
            chk1 ("b3_hold_valid", b_resp_valid, 1'b1);
            chk32("b3_hold_rdata", b_resp_rdata, 32'h0);
            chk1 ("b3_hold_rdy",   b_req_ready,  1'b0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk1 ("b3_done_resp", b_resp_valid, 1'b0);
        chk1 ("b3_done_rdy",  b_req_ready,  1'b1);

        // Reset in the second ACCESS cycle of a three-cycle store
        drive_req(1'b1, 32'h0000_0040, 32'h1111_2222, 2'd2, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        chk1 ("abort_pre_mv", b_mem_valid, 1'b1);
        rst_b = 1'b0;
        #1;
        chk1 ("abort_rdy",    b_req_ready, 1'b1);
        chk1 ("abort_mv",     b_mem_valid, 1'b0);
        chk1 ("abort_we",     b_mem_we,    1'b0);
        tick();
        chk1 ("abort_we2",    b_mem_we,    1'b0);
        tick();
        rst_b = 1'b1;
        tick();
        chk1 ("abort_we3",    b_mem_we,     1'b0);
        chk1 ("abort_idle",   b_req_ready,  1'b1);
        chk1 ("abort_nomv",   b_mem_valid,  1'b0);
        chk1 ("abort_nresp",  b_resp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1: cycles mem_valid is held per access; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  master can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU accepts the response.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores.
REQ-014 resp_error  output  1  misaligned access (macro-dependent).
REQ-015 mem_valid  output  1  memory request active.
REQ-016 mem_write_enable  output  1  memory write strobe.
REQ-017 mem_write_addr  output  32  word-aligned write address.
REQ-018 mem_write_data  output  32  lane-shifted store data.
REQ-019 mem_write_mask  output  4  byte-lane enables.
REQ-020 mem_read_addr  output  32  word-aligned read address.
REQ-021 mem_read_data  input  32  combinational read data from memory.

Function
REQ-022 The state machine SHALL have three states, IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 In IDLE, req_valid && req_ready SHALL capture the write flag, address, write data, size and unsigned flag, then move to ACCESS, or to RESP with resp_error=1 when the access is misaligned and the macro is defined.
REQ-024 In ACCESS, mem_valid SHALL be 1 for exactly ACCESS_CYCLES consecutive cycles, counted by a down-counter.
REQ-025 mem_write_enable SHALL be 1 only in the final ACCESS cycle of a store, so each store produces exactly one write.
REQ-026 mem_read_addr and mem_write_addr SHALL equal the captured address with bits [1:0] cleared.
REQ-027 mem_write_mask SHALL be 4'b0001<<off for a byte, 4'b0011<<off for a half and 4'b1111 for a word, where off = addr[1:0]; bits shifted past bit 3 SHALL be dropped.
REQ-028 mem_write_data SHALL be req_wdata<<(8*off), truncated to 32 bits.
REQ-029 On the final ACCESS cycle of a load, mem_read_data>>(8*off) SHALL be masked to the access size, extended per req_unsigned, and registered into resp_rdata; the master then moves to RESP.
REQ-030 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_error SHALL be stable until resp_ready=1, after which the master returns to IDLE on the next cycle.
REQ-031 Load-to-response latency SHALL be ACCESS_CYCLES+1 cycles after acceptance when resp_ready is held at 1.
REQ-032 req_valid SHALL be ignored outside IDLE, and captured fields SHALL NOT change mid-transaction.
REQ-033 When not in ACCESS, all mem_* outputs SHALL be 0.

Reset
REQ-034 While reset=0, the state SHALL be IDLE and every output except req_ready SHALL be 0; req_ready SHALL be 1.
REQ-035 Reset asserted during ACCESS or RESP SHALL abort the transaction immediately, with no write strobe issued after the assertion.

Configuration
REQ-036 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL skip ACCESS and respond with resp_error=1 and resp_rdata=0.
REQ-037 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed per REQ-027/028/029 with truncated lanes, and resp_error SHALL be tied to 0.

Verification
REQ-038 Word store to 0x80000004, data 0xDEADBEEF, ACCESS_CYCLES=1 -> exactly one cycle with mem_write_enable=1, mask 4'b1111, addr 0x80000004, then resp_valid.
REQ-039 Signed byte load from 0x80000003 with memory word 0x80123456 -> resp_rdata=0xFFFFFF80; the unsigned load gives 0x00000080; latency is 2 cycles.
REQ-040 Half store of 0x1234 to 0x80000002 -> mask 4'b1100, mem_write_data=0x12340000.
REQ-041 Word load at 0x80000001 -> resp_error=1 with no mem_valid pulse when the macro is defined; with the macro undefined, resp_error=0 and one access to 0x80000000.
REQ-042 ACCESS_CYCLES=3 store with resp_ready held 0 for 5 cycles -> mem_valid high for 3 cycles, write strobe on the 3rd cycle only, and resp_valid held stable for 5 cycles.
REQ-043 reset driven low in the 2nd ACCESS cycle of an ACCESS_CYCLES=3 store -> no write strobe, state IDLE, req_ready=1 immediately.
